uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
// PURPOSE
//   Transmit buffer feeding the UART serialiser (tx_core) inside the Avalon UART slave.
//   Accepts bytes from the register-file write path and stores them in a synchronous FIFO.
//   Dispatches one byte at a time over the tx_valid/tx_ready/tx_done handshake.
//   Reports level and status flags for the CSR block and interrupts.
// PARAMETERS
//   DEPTH     16  FIFO entries; must be a power of 2, >= 2
//   ADDR_W    4   log2(DEPTH)
//   AE_LEVEL  2   almost_empty asserts when fifo_level <= AE_LEVEL
// PORTS
//   tx_clk        in   1         clock; all logic on its rising edge
//   reset_n       in   1         asynchronous, active-low reset
//   wr_en         in   1         write strobe, one byte per cycle, already in tx_clk domain
//   wr_data       in   8         byte to enqueue
//   flush         in   1         clears all stored (not yet dispatched) bytes
//   ovf_clr       in   1         clears the sticky overflow flag
//   fifo_full     out  1         fifo_level == DEPTH
//   fifo_empty    out  1         fifo_level == 0
//   fifo_level    out  ADDR_W+1  stored entries, excluding the byte in flight
//   almost_empty  out  1         fifo_level <= AE_LEVEL
//   overflow      out  1         sticky: a write was dropped
//   busy          out  1         dispatcher not in IDLE (a byte is in flight)
//   tx_valid      out  1         to tx_core: byte available
//   tx_data       out  8         to tx_core: registered byte, stable from ISSUE until DONE
//   tx_ready      in   1         from tx_core: serialiser idle
//   tx_done       in   1         from tx_core: one-cycle pulse when stop bit is complete
// BEHAVIOUR
//   Reset: all outputs 0, except fifo_empty=1 and almost_empty=1. Pointers, level and out_reg are 0. FSM is IDLE.
//   Storage: wr_ptr/rd_ptr are ADDR_W bits wide, wrap modulo DEPTH. level is tracked as a separate ADDR_W+1 counter.
//   Write: accepted if !fifo_full, or if a pop occurs in the same cycle.
//     - A write to a full FIFO with no pop is dropped: contents unchanged, overflow<=1.
//   overflow is cleared only by ovf_clr. If a drop and ovf_clr occur together, the flag stays set.
//   Dispatch FSM (states IDLE, ISSUE, WAIT_DONE):
//     IDLE: if !fifo_empty && tx_ready -> pop the head into out_reg, rd_ptr++, level--, go to ISSUE.
//     ISSUE: tx_valid=1. If tx_ready -> WAIT_DONE; otherwise hold.
//     WAIT_DONE: tx_valid=0. On tx_done -> IDLE.
//   tx_data = out_reg at all times. out_reg changes only on a pop.
//   Latency: a write sampled at edge N into an empty, idle FIFO gives tx_valid high after edge N+2.
//   Back-to-back throughput: the next pop happens in the first IDLE cycle with tx_ready=1 after tx_done.
//   Simultaneous write + pop: level is unchanged, both pointers advance.
//   flush: wr_ptr=rd_ptr=0, level=0 on the next edge.
//     - Does not abort the in-flight byte, does not change the FSM, does not clear overflow.
//     - flush has priority over a same-cycle wr_en (the write is discarded, no overflow) and over a same-cycle pop (no pop).
//   tx_done seen outside WAIT_DONE is ignored.
//   Reset mid-frame: everything returns to reset values immediately (asynchronous); buffered bytes are lost.
// STRUCTURE
//   uart_pkg: FSM state localparams (IDLE=2'b00, ISSUE=2'b01, WAIT_DONE=2'b11), UART_DATA_W=8, default DEPTH.
//   Sub-module sync_fifo_mem: DEPTH x 8 register array with registered write port and combinational read at rd_ptr.
//   Pointer, level and flag logic stays in uart_tx_fifo, together with the dispatch FSM.
// TESTING
//   1. Write 0xA5 once, tx_ready=1, tx_core model connected -> tx_valid rises 2 cycles later, tx_data=0xA5, line shows 0,A5 LSB-first,1.
//   2. Write 0x01..0x10 back-to-back (16 bytes) -> fifo_full=1 after the 16th write if not yet dispatched. Bytes are transmitted in order 0x01..0x10, no gaps beyond the IDLE turnaround.
//   3. Fill to full with tx_ready=0, write 0xFF -> overflow=1, level=16, 0xFF never transmitted. Pulse ovf_clr -> overflow=0.
//   4. Full FIFO, tx_ready raised while wr_en=1 with 0x77 in the same cycle -> write accepted, level stays 16, 0x77 transmitted last.
//   5. Load 5 bytes; one is in flight (busy=1); pulse flush -> level=0, in-flight byte completes, nothing else is sent, busy clears after tx_done.
//   6. Assert reset_n=0 during WAIT_DONE -> tx_valid=0, fifo_empty=1, level=0, busy=0 immediately. Normal operation resumes after release.

Source files
------------

// File: rtl/uart_tx_fifo_pkg.sv
// Shared types and constants for the UART transmit buffer.
package uart_tx_fifo_pkg;

   localparam int UART_DATA_W   = 8;
   localparam int DEFAULT_DEPTH = 16;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'b00,
      ST_ISSUE     = 2'b01,
      ST_WAIT_DONE = 2'b11
   } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Write-path, status and tx_core handshake bundle of the UART transmit buffer.
interface uart_tx_fifo_if #(
   parameter int ADDR_W = 4
);
   import uart_tx_fifo_pkg::*;

   logic                   wr_en;
   logic [UART_DATA_W-1:0] wr_data;
   logic                   flush;
   logic                   ovf_clr;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic [ADDR_W:0]        fifo_level;
   logic                   almost_empty;
   logic                   overflow;
   logic                   busy;
   logic                   tx_valid;
   logic [UART_DATA_W-1:0] tx_data;
   logic                   tx_ready;
   logic                   tx_done;

   modport master (
      output wr_en, wr_data, flush, ovf_clr, tx_ready, tx_done,
      input  fifo_full, fifo_empty, fifo_level, almost_empty, overflow, busy,
             tx_valid, tx_data
   );

   modport slave (
      input  wr_en, wr_data, flush, ovf_clr, tx_ready, tx_done,
      output fifo_full, fifo_empty, fifo_level, almost_empty, overflow, busy,
             tx_valid, tx_data
   );

endinterface

// File: rtl/uart_tx_fifo_mem.sv
// Byte storage for the transmit FIFO: registered write, combinational read.
module sync_fifo_mem
   import uart_tx_fifo_pkg::*;
#(
   parameter int DEPTH  = DEFAULT_DEPTH,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic                   tx_clk,
   input  logic                   we_i,
   input  logic [ADDR_W-1:0]      waddr_i,
   input  logic [UART_DATA_W-1:0] wdata_i,
   input  logic [ADDR_W-1:0]      raddr_i,
   output logic [UART_DATA_W-1:0] rdata_o
);

   logic [UART_DATA_W-1:0] mem_q [DEPTH];

   always_ff @(posedge tx_clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmit buffer: FIFO pointers/level/flags plus a dispatcher that hands
// one byte at a time to tx_core over tx_valid/tx_ready/tx_done.
//
// state        | meaning
// ST_IDLE      | nothing in flight; pops the head when data and tx_ready
// ST_ISSUE     | out_reg loaded; tx_valid raised, waits for tx_ready
// ST_WAIT_DONE | byte accepted by tx_core; waits for tx_done
module uart_tx_fifo
   import uart_tx_fifo_pkg::*;
#(
   parameter int DEPTH    = DEFAULT_DEPTH,
   parameter int ADDR_W   = $clog2(DEPTH),
   parameter int AE_LEVEL = 2
) (
   input  logic           tx_clk,
   input  logic           reset_n,
   uart_tx_fifo_if.slave  bus
);

   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] AE_L    = (ADDR_W+1)'(AE_LEVEL);

   logic [ADDR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]        level_q, level_d;
   logic                   overflow_q, overflow_d;
   tx_state_e              state_q;
   logic [UART_DATA_W-1:0] out_reg_q;
   logic                   tx_valid_q;
   logic                   busy_q;
   logic [UART_DATA_W-1:0] head_data;
   logic                   full, empty, pop, push, drop;

   assign full  = (level_q == DEPTH_L);
   assign empty = (level_q == '0);

   // flush wins over both a same-cycle pop and a same-cycle write
   assign pop  = (state_q == ST_IDLE) && !empty && bus.tx_ready && !bus.flush;
   assign push = bus.wr_en && !bus.flush && (!full || pop);
   assign drop = bus.wr_en && !bus.flush && full && !pop;

   sync_fifo_mem #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_mem (
      .tx_clk  (tx_clk),
      .we_i    (push),
      .waddr_i (wr_ptr_q),
      .wdata_i (bus.wr_data),
      .raddr_i (rd_ptr_q),
      .rdata_o (head_data)
   );

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      level_d    = level_q;
      overflow_d = overflow_q;
      if (bus.flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
         endcase
      end
      if (drop) begin
         overflow_d = 1'b1;
      end else if (bus.ovf_clr) begin
         overflow_d = 1'b0;
      end
   end

   always_ff @(posedge tx_clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         overflow_q <= overflow_d;
      end
   end

   // tx_valid rises one cycle after entering ISSUE, so a handshake is only
   // taken once tx_valid is actually visible to tx_core
   always_ff @(posedge tx_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         out_reg_q  <= '0;
         tx_valid_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (pop) begin
                  out_reg_q <= head_data;
                  busy_q    <= 1'b1;
                  state_q   <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (!tx_valid_q) begin
                  tx_valid_q <= 1'b1;
               end else if (bus.tx_ready) begin
                  tx_valid_q <= 1'b0;
                  state_q    <= ST_WAIT_DONE;
               end
            end
            ST_WAIT_DONE: begin
               if (bus.tx_done) begin
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               tx_valid_q <= 1'b0;
               busy_q     <= 1'b0;
               state_q    <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.fifo_full    = full;
   assign bus.fifo_empty   = empty;
   assign bus.fifo_level   = level_q;
   assign bus.almost_empty = (level_q <= AE_L);
   assign bus.overflow     = overflow_q;
   assign bus.busy         = busy_q;
   assign bus.tx_valid     = tx_valid_q;
   assign bus.tx_data      = out_reg_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a simple tx_core model on the handshake.
module tb_uart_tx_fifo;
   import uart_tx_fifo_pkg::*;

   localparam int DEPTH     = 16;
   localparam int ADDR_W    = 4;
   localparam int AE_LEVEL  = 2;
   localparam int BIT_CYC   = 2;
   localparam int FRAME_CYC = 10 * BIT_CYC;

   logic tx_clk  = 1'b0;
   logic reset_n = 1'b0;
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;

   uart_tx_fifo_if #(.ADDR_W(ADDR_W)) bus ();

   uart_tx_fifo #(
      .DEPTH    (DEPTH),
      .ADDR_W   (ADDR_W),
      .AE_LEVEL (AE_LEVEL)
   ) dut (
      .tx_clk  (tx_clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 tx_clk = ~tx_clk;
   always @(posedge tx_clk) cyc <= cyc + 1;

   // tx_core model: accepts on valid&ready, holds ready low for a frame, pulses done
   logic       ready_m, done_m, busy_m, hold_rdy;
   int         cnt_m;
   logic [7:0] cur_m;
   logic [7:0] cap_q[$];
   int         acc_t[$];
   int         done_t[$];
   int         stab_err = 0;

   assign bus.tx_ready = ready_m & ~hold_rdy;
   assign bus.tx_done  = done_m;

   always @(posedge tx_clk or negedge reset_n) begin
      if (!reset_n) begin
         ready_m <= 1'b1;
         done_m  <= 1'b0;
         busy_m  <= 1'b0;
         cnt_m   <= 0;
         cur_m   <= 8'h00;
      end else begin
         if (done_m) begin
            done_m  <= 1'b0;
            ready_m <= 1'b1;
            done_t.push_back(cyc);
         end
         if (busy_m && bus.tx_data !== cur_m) stab_err <= stab_err + 1;
         if (bus.tx_valid && bus.tx_ready) begin
            cur_m   <= bus.tx_data;
            cap_q.push_back(bus.tx_data);
            acc_t.push_back(cyc);
            ready_m <= 1'b0;
            busy_m  <= 1'b1;
            cnt_m   <= FRAME_CYC - 1;
         end else if (busy_m) begin
            if (cnt_m == 0) begin
               busy_m <= 1'b0;
               done_m <= 1'b1;
            end else begin
               cnt_m <= cnt_m - 1;
            end
         end
      end
   end

   task automatic write_byte(input logic [7:0] b);
      bus.wr_en   = 1'b1;
      bus.wr_data = b;
      @(negedge tx_clk);
      bus.wr_en   = 1'b0;
   endtask

   task automatic wait_drain(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge tx_clk);
         if (!bus.busy && bus.fifo_empty && !busy_m && !done_m) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      bus.wr_en = 1'b0; bus.wr_data = 8'h00; bus.flush = 1'b0; bus.ovf_clr = 1'b0;
      hold_rdy = 1'b0;
      reset_n = 1'b0;
      repeat (3) @(negedge tx_clk);
      checks++; if (bus.fifo_empty !== 1'b1) begin failures++; $display("FAIL rst_empty got=%0b exp=1", bus.fifo_empty); end
      checks++; if (bus.almost_empty !== 1'b1) begin failures++; $display("FAIL rst_almost_empty got=%0b exp=1", bus.almost_empty); end
      checks++; if (bus.fifo_full !== 1'b0) begin failures++; $display("FAIL rst_full got=%0b exp=0", bus.fifo_full); end
      checks++; if (bus.fifo_level !== 5'd0) begin failures++; $display("FAIL rst_level got=%0d exp=0", bus.fifo_level); end
      checks++; if ({bus.overflow, bus.busy, bus.tx_valid} !== 3'b000) begin failures++; $display("FAIL rst_flags got=%03b exp=000", {bus.overflow, bus.busy, bus.tx_valid}); end
      checks++; if (bus.tx_data !== 8'h00) begin failures++; $display("FAIL rst_tx_data got=%0h exp=0", bus.tx_data); end
      reset_n = 1'b1;
      @(negedge tx_clk);
      checks++; if ({bus.fifo_empty, bus.busy, bus.tx_valid} !== 3'b100) begin failures++; $display("FAIL post_rst_idle got=%03b exp=100", {bus.fifo_empty, bus.busy, bus.tx_valid}); end
   endtask

   task automatic test_single();
      int base;
      int s0;
      bit ok;
      base = cap_q.size();
      s0   = stab_err;
      write_byte(8'hA5);
      checks++; if (bus.tx_valid !== 1'b0 || bus.fifo_level !== 5'd1) begin failures++; $display("FAIL single_n got valid=%0b level=%0d exp valid=0 level=1", bus.tx_valid, bus.fifo_level); end
      @(negedge tx_clk);
      checks++; if (bus.tx_valid !== 1'b0 || bus.busy !== 1'b1 || bus.fifo_level !== 5'd0) begin failures++; $display("FAIL single_n1 got valid=%0b busy=%0b level=%0d exp 0 1 0", bus.tx_valid, bus.busy, bus.fifo_level); end
      checks++; if (bus.tx_data !== 8'hA5) begin failures++; $display("FAIL single_data got=%0h exp=a5", bus.tx_data); end
      @(negedge tx_clk);
      checks++; if (bus.tx_valid !== 1'b1) begin failures++; $display("FAIL single_latency got valid=%0b exp=1", bus.tx_valid); end
      @(negedge tx_clk);
      checks++; if (bus.tx_valid !== 1'b0) begin failures++; $display("FAIL single_accept got valid=%0b exp=0", bus.tx_valid); end
      wait_drain(200, ok);
      checks++; if (!ok) begin failures++; $display("FAIL single_drain got=timeout exp=idle"); end
      checks++; if (cap_q.size() !== base + 1 || cap_q[base] !== 8'hA5) begin failures++; $display("FAIL single_sent got count=%0d exp count=1 byte=a5", cap_q.size() - base); end
      checks++; if (stab_err !== s0) begin failures++; $display("FAIL single_stable got=%0d exp=%0d", stab_err, s0); end
   endtask

   task automatic test_back_to_back();
      int  base, ab, db;
      bit  ok;
      base = cap_q.size(); ab = acc_t.size(); db = done_t.size();
      hold_rdy = 1'b1;
      for (int i = 0; i < 16; i++) begin
         write_byte(8'(i + 1));
         if (i == 1) begin
            checks++; if (bus.almost_empty !== 1'b1 || bus.fifo_level !== 5'd2) begin failures++; $display("FAIL ae_at_2 got ae=%0b level=%0d exp ae=1 level=2", bus.almost_empty, bus.fifo_level); end
         end
         if (i == 2) begin
            checks++; if (bus.almost_empty !== 1'b0 || bus.fifo_level !== 5'd3) begin failures++; $display("FAIL ae_at_3 got ae=%0b level=%0d exp ae=0 level=3", bus.almost_empty, bus.fifo_level); end
         end
      end
      checks++; if (bus.fifo_full !== 1'b1 || bus.fifo_level !== 5'd16 || bus.fifo_empty !== 1'b0) begin failures++; $display("FAIL b2b_full got full=%0b level=%0d exp full=1 level=16", bus.fifo_full, bus.fifo_level); end
      hold_rdy = 1'b0;
      wait_drain(2000, ok);
      checks++; if (!ok) begin failures++; $display("FAIL b2b_drain got=timeout exp=idle"); end
      checks++; if (cap_q.size() !== base + 16) begin failures++; $display("FAIL b2b_count got=%0d exp=16", cap_q.size() - base); end
      else begin
         for (int i = 0; i < 16; i++) begin
            checks++; if (cap_q[base+i] !== 8'(i + 1)) begin failures++; $display("FAIL b2b_order[%0d] got=%0h exp=%0h", i, cap_q[base+i], i + 1); end
         end
         for (int i = 1; i < 16; i++) begin
            checks++; if (acc_t[ab+i] - done_t[db+i-1] !== 3) begin failures++; $display("FAIL b2b_gap[%0d] got=%0d exp=3", i, acc_t[ab+i] - done_t[db+i-1]); end
         end
      end
   endtask

   task automatic test_overflow_and_full_write();
      int base;
      bit ok;
      hold_rdy = 1'b1;
      for (int i = 0; i < 16; i++) write_byte(8'(8'h20 + i));
      write_byte(8'hFF);
      checks++; if (bus.overflow !== 1'b1 || bus.fifo_level !== 5'd16) begin failures++; $display("FAIL ovf_set got ovf=%0b level=%0d exp ovf=1 level=16", bus.overflow, bus.fifo_level); end
      bus.ovf_clr = 1'b1;
      write_byte(8'hFF);
      bus.ovf_clr = 1'b0;
      checks++; if (bus.overflow !== 1'b1) begin failures++; $display("FAIL ovf_drop_beats_clr got=%0b exp=1", bus.overflow); end
      bus.ovf_clr = 1'b1;
      @(negedge tx_clk);
      bus.ovf_clr = 1'b0;
      checks++; if (bus.overflow !== 1'b0 || bus.fifo_level !== 5'd16) begin failures++; $display("FAIL ovf_clr got ovf=%0b level=%0d exp ovf=0 level=16", bus.overflow, bus.fifo_level); end
      base = cap_q.size();
      hold_rdy = 1'b0;
      write_byte(8'h77);
      checks++; if (bus.fifo_level !== 5'd16 || bus.overflow !== 1'b0) begin failures++; $display("FAIL full_push_pop got level=%0d ovf=%0b exp level=16 ovf=0", bus.fifo_level, bus.overflow); end
      checks++; if (bus.tx_data !== 8'h20 || bus.busy !== 1'b1) begin failures++; $display("FAIL full_push_pop_head got=%0h exp=20", bus.tx_data); end
      wait_drain(3000, ok);
      checks++; if (!ok) begin failures++; $display("FAIL full_drain got=timeout exp=idle"); end
      checks++; if (cap_q.size() !== base + 17) begin failures++; $display("FAIL full_count got=%0d exp=17", cap_q.size() - base); end
      else begin
         for (int i = 0; i < 16; i++) begin
            checks++; if (cap_q[base+i] !== 8'(8'h20 + i)) begin failures++; $display("FAIL full_order[%0d] got=%0h exp=%0h", i, cap_q[base+i], 8'h20 + i); end
         end
         checks++; if (cap_q[base+16] !== 8'h77) begin failures++; $display("FAIL full_last got=%0h exp=77", cap_q[base+16]); end
      end
   endtask

   task automatic test_flush();
      int base;
      bit ok;
      base = cap_q.size();
      hold_rdy = 1'b0;
      for (int i = 0; i < 5; i++) write_byte(8'(8'h51 + i));
      checks++; if (bus.fifo_level !== 5'd4 || bus.busy !== 1'b1) begin failures++; $display("FAIL flush_pre got level=%0d busy=%0b exp level=4 busy=1", bus.fifo_level, bus.busy); end
      bus.flush = 1'b1;
      write_byte(8'h99);
      bus.flush = 1'b0;
      checks++; if (bus.fifo_level !== 5'd0 || bus.fifo_empty !== 1'b1 || bus.overflow !== 1'b0) begin failures++; $display("FAIL flush_clear got level=%0d empty=%0b ovf=%0b exp 0 1 0", bus.fifo_level, bus.fifo_empty, bus.overflow); end
      checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL flush_inflight got busy=%0b exp=1", bus.busy); end
      wait_drain(500, ok);
      checks++; if (!ok || bus.busy !== 1'b0) begin failures++; $display("FAIL flush_drain got busy=%0b exp=0", bus.busy); end
      checks++; if (cap_q.size() !== base + 1 || cap_q[base] !== 8'h51) begin failures++; $display("FAIL flush_sent got count=%0d exp count=1 byte=51", cap_q.size() - base); end
   endtask

   task automatic test_reset_mid_frame();
      int base;
      bit ok;
      bit seen;
      hold_rdy = 1'b0;
      write_byte(8'h3C);
      write_byte(8'h3D);
      write_byte(8'h3E);
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (busy_m) begin seen = 1'b1; break; end
         @(negedge tx_clk);
      end
      checks++; if (!seen) begin failures++; $display("FAIL midrst_reach got=timeout exp=in_flight"); end
      #2;
      reset_n = 1'b0;
      #1;
      checks++; if (bus.tx_valid !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("FAIL midrst_ctl got valid=%0b busy=%0b exp 0 0", bus.tx_valid, bus.busy); end
      checks++; if (bus.fifo_empty !== 1'b1 || bus.fifo_level !== 5'd0) begin failures++; $display("FAIL midrst_fifo got empty=%0b level=%0d exp 1 0", bus.fifo_empty, bus.fifo_level); end
      @(negedge tx_clk);
      @(negedge tx_clk);
      reset_n = 1'b1;
      @(negedge tx_clk);
      base = cap_q.size();
      write_byte(8'h42);
      wait_drain(500, ok);
      checks++; if (!ok) begin failures++; $display("FAIL midrst_drain got=timeout exp=idle"); end
      checks++; if (cap_q.size() !== base + 1 || cap_q[base] !== 8'h42) begin failures++; $display("FAIL midrst_resume got count=%0d exp count=1 byte=42", cap_q.size() - base); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_overflow_and_full_write();
      test_flush();
      test_reset_mid_frame();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
